// File: rtl/stack_pkg.sv
// Shared defaults and request decoding for the LIFO stack.
package stack_pkg;

    localparam int unsigned STACK_WIDTH = 16;
    localparam int unsigned STACK_DEPTH = 8;

    // Encoding is {push, pop}, so the request bits cast straight onto it.
    typedef enum logic [1:0] {
        OP_NONE = 2'b00,
        OP_POP  = 2'b01,
        OP_PUSH = 2'b10,
        OP_SWAP = 2'b11
    } op_e;

    function automatic op_e decode_op(input logic push, input logic pop);
        return op_e'({push, pop});
    endfunction

endpackage

// File: rtl/lifo_stack_if.sv
// Request/status bundle between the datapath (master) and the stack (slave).
interface lifo_stack_if
    import stack_pkg::*;
#(
    parameter int unsigned WIDTH = STACK_WIDTH,
    parameter int unsigned DEPTH = STACK_DEPTH,
    parameter int unsigned CW    = $clog2(DEPTH + 1)
);

    logic             clear;
    logic             push;
    logic             pop;
    logic [WIDTH-1:0] din;
    logic [WIDTH-1:0] pop_data;
    logic             pop_valid;
    logic [WIDTH-1:0] top;
    logic [CW-1:0]    count;
    logic             full;
    logic             empty;
    logic             ovf;
    logic             unf;

    modport master (
        output clear, push, pop, din,
        input  pop_data, pop_valid, top, count, full, empty, ovf, unf
    );

    modport slave (
        input  clear, push, pop, din,
        output pop_data, pop_valid, top, count, full, empty, ovf, unf
    );

endinterface

// File: rtl/stack_ram.sv
// DEPTH x WIDTH register array: one synchronous write port, one asynchronous read port.
module stack_ram #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned DEPTH = 8,
    parameter int unsigned AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    localparam logic [AW:0] DepthW = (AW + 1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];

    // Storage write; contents deliberately not reset.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Asynchronous read; addresses past the last entry (non power-of-two DEPTH) read as 0.
    always_comb begin
        rdata = '0;
        if ({1'b0, raddr} < DepthW) begin
            rdata = mem[raddr];
        end
    end

endmodule

// File: rtl/lifo_stack.sv
// Clocked LIFO: count doubles as the stack pointer, mem[count-1] is the top entry.
module lifo_stack
    import stack_pkg::*;
#(
    parameter int unsigned WIDTH = STACK_WIDTH,
    parameter int unsigned DEPTH = STACK_DEPTH
) (
    input logic         clk,
    input logic         rst,
    lifo_stack_if.slave bus
);

    localparam int unsigned CW = $clog2(DEPTH + 1);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam logic [CW-1:0] DepthC = CW'(DEPTH);

    logic [CW-1:0]    count_q, count_d;
    logic [WIDTH-1:0] pop_data_q, pop_data_d;
    logic             pop_valid_q, pop_valid_d;
    logic             ovf_q, ovf_d;
    logic             unf_q, unf_d;

    logic             full;
    logic             empty;
    logic [AW-1:0]    top_idx;
    logic [AW-1:0]    push_idx;
    logic [WIDTH-1:0] rdata;
    logic             we;
    logic [AW-1:0]    waddr;
    op_e              op;

    assign full     = (count_q == DepthC);
    assign empty    = (count_q == '0);
    // Wraps when empty; the read result is masked off in that case.
    assign top_idx  = AW'(count_q - 1'b1);
    // Truncates to 0 when full; never used for a write then.
    assign push_idx = AW'(count_q);
    assign op       = decode_op(bus.push, bus.pop);

    stack_ram #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_ram (
        .clk   (clk),
        .we    (we),
        .waddr (waddr),
        .wdata (bus.din),
        .raddr (top_idx),
        .rdata (rdata)
    );

    // Next-state decode: clear wins, then the (push, pop) request.
    always_comb begin
        count_d     = count_q;
        pop_data_d  = pop_data_q;
        pop_valid_d = 1'b0;
        ovf_d       = ovf_q;
        unf_d       = unf_q;
        we          = 1'b0;
        waddr       = push_idx;
        if (bus.clear) begin
            count_d    = '0;
            pop_data_d = '0;
            ovf_d      = 1'b0;
            unf_d      = 1'b0;
        end else begin
            unique case (op)
                OP_NONE: begin
                end
                OP_PUSH: begin
                    if (!full) begin
                        we      = 1'b1;
                        count_d = count_q + 1'b1;
                    end else begin
                        ovf_d = 1'b1;
                    end
                end
                OP_POP: begin
                    if (!empty) begin
                        pop_data_d  = rdata;
                        pop_valid_d = 1'b1;
                        count_d     = count_q - 1'b1;
                    end else begin
                        unf_d = 1'b1;
                    end
                end
                OP_SWAP: begin
                    pop_valid_d = 1'b1;
                    if (!empty) begin
                        // Replace top: old top out, din written in its place.
                        pop_data_d = rdata;
                        we         = 1'b1;
                        waddr      = top_idx;
                    end else begin
                        // Nothing stored: din passes straight through.
                        pop_data_d = bus.din;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // State registers with asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q     <= '0;
            pop_data_q  <= '0;
            pop_valid_q <= 1'b0;
            ovf_q       <= 1'b0;
            unf_q       <= 1'b0;
        end else begin
            count_q     <= count_d;
            pop_data_q  <= pop_data_d;
            pop_valid_q <= pop_valid_d;
            ovf_q       <= ovf_d;
            unf_q       <= unf_d;
        end
    end

    // Status outputs are functions of state only.
    always_comb begin
        bus.count     = count_q;
        bus.full      = full;
        bus.empty     = empty;
        bus.top       = empty ? '0 : rdata;
        bus.pop_data  = pop_data_q;
        bus.pop_valid = pop_valid_q;
        bus.ovf       = ovf_q;
        bus.unf       = unf_q;
    end

endmodule

// File: tb/tb_lifo_stack.sv
module tb_lifo_stack;

    localparam int unsigned WIDTH = 16;
    localparam int unsigned DEPTH = 8;

    logic clk;
    logic rst;

    lifo_stack_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus ();

    lifo_stack #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_pass  = 0;
    int n_total = 0;

    // Reference model: a queue whose back is the top of stack.
    logic [WIDTH-1:0] m_q[$];
    logic [WIDTH-1:0] m_pop_data;
    logic             m_pop_valid;
    logic             m_ovf;
    logic             m_unf;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic model_reset();
        m_q.delete();
        m_pop_data  = '0;
        m_pop_valid = 1'b0;
        m_ovf       = 1'b0;
        m_unf       = 1'b0;
    endtask

    task automatic check_all(input string tag);
        logic [WIDTH-1:0] exp_top;
        exp_top = (m_q.size() > 0) ? m_q[m_q.size()-1] : '0;
        check({tag, ".count"}, 32'(bus.count), 32'(m_q.size()));
        check({tag, ".full"}, 32'(bus.full), 32'(m_q.size() == DEPTH));
        check({tag, ".empty"}, 32'(bus.empty), 32'(m_q.size() == 0));
        check({tag, ".top"}, 32'(bus.top), 32'(exp_top));
        check({tag, ".pop_data"}, 32'(bus.pop_data), 32'(m_pop_data));
        check({tag, ".pop_valid"}, 32'(bus.pop_valid), 32'(m_pop_valid));
        check({tag, ".ovf"}, 32'(bus.ovf), 32'(m_ovf));
        check({tag, ".unf"}, 32'(bus.unf), 32'(m_unf));
    endtask

    // One clock: drive on the falling edge, model the rising edge, sample 1 time unit later.
    task automatic step(input string tag, input logic c, input logic pu, input logic po,
                        input logic [WIDTH-1:0] d);
        @(negedge clk);
        bus.clear = c;
        bus.push  = pu;
        bus.pop   = po;
        bus.din   = d;
        @(posedge clk);
        m_pop_valid = 1'b0;
        if (c) begin
            model_reset();
        end else if (pu && !po) begin
            if (m_q.size() < DEPTH) m_q.push_back(d);
            else m_ovf = 1'b1;
        end else if (po && !pu) begin
            if (m_q.size() > 0) begin
                m_pop_data  = m_q.pop_back();
                m_pop_valid = 1'b1;
            end else begin
                m_unf = 1'b1;
            end
        end else if (pu && po) begin
            m_pop_valid = 1'b1;
            if (m_q.size() > 0) begin
                m_pop_data           = m_q[m_q.size()-1];
                m_q[m_q.size()-1]    = d;
            end else begin
                m_pop_data = d;
            end
        end
        #1;
        check_all(tag);
    endtask

    // Asynchronous reset pulse placed between edges; outputs checked before the next edge.
    task automatic async_reset(input string tag);
        @(negedge clk);
        bus.clear = 1'b0;
        bus.push  = 1'b0;
        bus.pop   = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        model_reset();
        check_all(tag);
        check({tag, ".top0"}, 32'(bus.top), 32'h0);
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        rst       = 1'b1;
        bus.clear = 1'b0;
        bus.push  = 1'b0;
        bus.pop   = 1'b0;
        bus.din   = '0;
        model_reset();
        #12;
        check_all("reset");
        @(negedge clk);
        rst = 1'b0;

        // 1: fill to full
        for (int i = 1; i <= 8; i++) step("fill", 1'b0, 1'b1, 1'b0, 16'(i));
        check("fill.top8", 32'(bus.top), 32'h0008);
        check("fill.full", 32'(bus.full), 32'h1);

        // 2: overflow, then drain
        step("ovf", 1'b0, 1'b1, 1'b0, 16'hDEAD);
        check("ovf.flag", 32'(bus.ovf), 32'h1);
        for (int i = 8; i >= 1; i--) begin
            step("drain", 1'b0, 1'b0, 1'b1, 16'h0);
            check("drain.val", 32'(bus.pop_data), 32'(i));
        end
        step("idle", 1'b0, 1'b0, 1'b0, 16'h0);
        check("idle.valid", 32'(bus.pop_valid), 32'h0);

        // 3: underflow, then clear
        step("unf", 1'b0, 1'b0, 1'b1, 16'h0);
        check("unf.data_held", 32'(bus.pop_data), 32'h0001);
        step("clr", 1'b1, 1'b0, 1'b0, 16'h0);
        check("clr.unf", 32'(bus.unf), 32'h0);

        // 4: swap with entries, then bypass on empty
        step("ld", 1'b0, 1'b1, 1'b0, 16'h00AA);
        step("ld", 1'b0, 1'b1, 1'b0, 16'h00BB);
        step("swap", 1'b0, 1'b1, 1'b1, 16'h00CC);
        check("swap.data", 32'(bus.pop_data), 32'h00BB);
        check("swap.top", 32'(bus.top), 32'h00CC);
        step("pop", 1'b0, 1'b0, 1'b1, 16'h0);
        step("pop", 1'b0, 1'b0, 1'b1, 16'h0);
        step("byp", 1'b0, 1'b1, 1'b1, 16'h1234);
        check("byp.data", 32'(bus.pop_data), 32'h1234);

        // 5: async reset mid-sequence
        for (int i = 0; i < 3; i++) step("pre_rst", 1'b0, 1'b1, 1'b0, 16'(16'h0100 + i));
        step("pre_rst_pop", 1'b0, 1'b0, 1'b1, 16'h0);
        async_reset("arst");

        // 6: push + clear with count=5
        for (int i = 0; i < 5; i++) step("five", 1'b0, 1'b1, 1'b0, 16'(16'h0200 + i));
        step("ovf_set", 1'b0, 1'b1, 1'b1, 16'h0300);
        step("pushclr", 1'b1, 1'b1, 1'b0, 16'h0BAD);
        step("after_clr", 1'b0, 1'b0, 1'b0, 16'h0);

        // Random traffic, biased to sweep between empty and full.
        for (int n = 0; n < 500; n++) begin
            int unsigned r;
            logic pu;
            logic po;
            r  = $urandom_range(99);
            pu = (n % 64 < 32) ? (r < 70) : (r < 30);
            po = ($urandom_range(99) < 50);
            if ($urandom_range(79) == 0) begin
                async_reset("rnd_arst");
            end else begin
                step("rnd", ($urandom_range(49) == 0), pu, po, 16'($urandom));
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
